// File: rtl/snoop_resp_if.sv
// Snoop-bus, data-array, writeback and local-update signals of one snoop_resp instance.
// slave = the responder, master = bus/cache-controller side.
interface snoop_resp_if #(
  parameter int unsigned LINES  = 8,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned IdxW = $clog2(LINES);

  logic              cpu_search;
  logic [ADDR_W-1:0] BOCI;
  logic              invalidate_from_other_cpu;
  logic              cpu_search_found;
  logic              snoop_done;
  logic [DATA_W-1:0] send_other_proc_data;
  logic              dary_re;
  logic [IdxW-1:0]   dary_addr;
  logic [DATA_W-1:0] dary_rdata;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_rdy;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [1:0]        loc_state;
  logic [1:0]        loc_state_out;
  logic              loc_busy;

  modport slave (
    input  cpu_search, BOCI, invalidate_from_other_cpu, dary_rdata, wb_rdy,
           loc_we, loc_addr, loc_state,
    output cpu_search_found, snoop_done, send_other_proc_data, dary_re, dary_addr,
           wb_req, wb_addr, wb_data, loc_state_out, loc_busy
  );

  modport master (
    output cpu_search, BOCI, invalidate_from_other_cpu, dary_rdata, wb_rdy,
           loc_we, loc_addr, loc_state,
    input  cpu_search_found, snoop_done, send_other_proc_data, dary_re, dary_addr,
           wb_req, wb_addr, wb_data, loc_state_out, loc_busy
  );
endinterface

// File: rtl/snoop_resp.sv
// Per-CPU MSI snoop responder owning the local direct-mapped cache tag/state array.
// Define SNOOP_WB_EN to write forwarded Modified lines back to d_mem before responding.
module snoop_resp #(
  parameter int unsigned LINES  = 8,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  snoop_resp_if.slave bus
);
  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = ADDR_W - IdxW;

  localparam logic [1:0] MsiI = 2'b00;
  localparam logic [1:0] MsiS = 2'b01;
  localparam logic [1:0] MsiM = 2'b10;

  typedef enum logic [2:0] {StIdle, StLookup, StRead, StWb, StResp} fsm_e;

  fsm_e              fsm_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inv_q;
  logic              found_q;
  logic              done_q;
  logic [DATA_W-1:0] fwd_q;
  logic [TagW-1:0]   tag_q [LINES];
  logic [1:0]        st_q  [LINES];

  logic [IdxW-1:0] snp_idx, loc_idx;
  logic [TagW-1:0] snp_tag, loc_tag;
  logic            snp_hit_s, snp_hit_m, loc_busy;
  logic [1:0]      snp_st, loc_st;

  assign snp_idx   = addr_q[IdxW-1:0];
  assign snp_tag   = addr_q[ADDR_W-1:IdxW];
  assign loc_idx   = bus.loc_addr[IdxW-1:0];
  assign loc_tag   = bus.loc_addr[ADDR_W-1:IdxW];
  assign snp_st    = st_q[snp_idx];
  assign snp_hit_s = (tag_q[snp_idx] == snp_tag) && (snp_st == MsiS);
  assign snp_hit_m = (tag_q[snp_idx] == snp_tag) && (snp_st == MsiM);
  assign loc_busy  = (fsm_q != StIdle) && (loc_idx == snp_idx);

  // Read strobe must go out in LOOKUP so the synchronous array answers during READ.
  assign bus.dary_re              = (fsm_q == StLookup) && snp_hit_m;
  assign bus.dary_addr            = snp_idx;
  assign bus.loc_busy             = loc_busy;
  assign bus.cpu_search_found     = found_q;
  assign bus.snoop_done           = done_q;
  assign bus.send_other_proc_data = fwd_q;

  always_comb begin
    loc_st            = st_q[loc_idx];
    bus.loc_state_out = MsiI;
    if ((tag_q[loc_idx] == loc_tag) && ((loc_st == MsiS) || (loc_st == MsiM))) begin
      bus.loc_state_out = loc_st;
    end
  end

`ifdef SNOOP_WB_EN
  logic              wb_req_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  assign bus.wb_req  = wb_req_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
`else
  logic unused_wb_rdy;

  assign unused_wb_rdy = bus.wb_rdy;
  assign bus.wb_req    = 1'b0;
  assign bus.wb_addr   = '0;
  assign bus.wb_data   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      addr_q  <= '0;
      inv_q   <= 1'b0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
      fwd_q   <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        st_q[i]  <= MsiI;
      end
`ifdef SNOOP_WB_EN
      wb_req_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      // Snoop updates below are issued after this, so they win on the same line.
      if (bus.loc_we && !loc_busy) begin
        tag_q[loc_idx] <= loc_tag;
        st_q[loc_idx]  <= bus.loc_state;
      end
      unique case (fsm_q)
        StIdle: begin
          if (bus.cpu_search) begin
            addr_q <= bus.BOCI;
            inv_q  <= bus.invalidate_from_other_cpu;
            fsm_q  <= StLookup;
          end
        end
        StLookup: begin
          found_q <= snp_hit_s || snp_hit_m;
          if (snp_hit_m) begin
            fsm_q <= StRead;
          end else begin
            if (snp_hit_s && inv_q) st_q[snp_idx] <= MsiI;
            fsm_q  <= StResp;
            done_q <= 1'b1;
          end
        end
        StRead: begin
          fwd_q <= bus.dary_rdata;
`ifdef SNOOP_WB_EN
          wb_data_q <= bus.dary_rdata;
          wb_addr_q <= addr_q;
          wb_req_q  <= 1'b1;
          fsm_q     <= StWb;
`else
          // Ownership moves with the forwarded data; requester installs the line in M.
          st_q[snp_idx] <= MsiI;
          fsm_q         <= StResp;
          done_q        <= 1'b1;
`endif
        end
        StWb: begin
`ifdef SNOOP_WB_EN
          if (bus.wb_rdy) begin
            wb_req_q      <= 1'b0;
            st_q[snp_idx] <= inv_q ? MsiI : MsiS;
            fsm_q         <= StResp;
            done_q        <= 1'b1;
          end
`else
          fsm_q <= StIdle;
`endif
        end
        StResp:  fsm_q <= StIdle;
        default: fsm_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_snoop_resp.sv
// Scoreboard bench for snoop_resp: expectations are queued per snoop and checked at snoop_done.
// Honours SNOOP_WB_EN the same way as the design.
module tb_snoop_resp;
  localparam int unsigned LINES  = 8;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] MsiI = 2'b00;
  localparam logic [1:0] MsiS = 2'b01;
  localparam logic [1:0] MsiM = 2'b10;

`ifdef SNOOP_WB_EN
  localparam logic [1:0] MsiAfterRd = MsiS;
`else
  localparam logic [1:0] MsiAfterRd = MsiI;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_resp_if #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  snoop_resp #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [LINES];
  always @(posedge clk) if (bus.dary_re) bus.dary_rdata <= mem[bus.dary_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit                found;
    int                done_cyc;
    bit                fwd_chk;
    logic [DATA_W-1:0] fwd;
    bit                wb_exp;
    int                wb_first;
    int                wb_last;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        st;
  } exp_t;
  exp_t sb[$];

  task automatic loc_write(input logic [ADDR_W-1:0] a, input logic [1:0] s);
    @(negedge clk);
    bus.loc_we = 1'b1; bus.loc_addr = a; bus.loc_state = s;
    @(negedge clk);
    bus.loc_we = 1'b0;
  endtask

  task automatic peek(input logic [ADDR_W-1:0] a, output logic [1:0] s);
    bus.loc_addr = a;
    #1;
    s = bus.loc_state_out;
  endtask

  // Issues one snoop, queues its expectation, then follows it to snoop_done.
  task automatic run_snoop(input logic [ADDR_W-1:0] a, input bit inv, input bit is_m,
                           input int k, input bit found, input logic [DATA_W-1:0] fwd,
                           input logic [1:0] st, input bit busy_chk);
    exp_t e, g;
    int n, wb_cnt, wb_first, wb_last;
    bit fin;
    wb_cnt = 0; wb_first = -1; wb_last = -1; fin = 1'b0;
    @(negedge clk);
    n = cyc;
    bus.cpu_search = 1'b1; bus.BOCI = a; bus.invalidate_from_other_cpu = inv;
    bus.loc_addr = a; bus.loc_we = 1'b0; bus.wb_rdy = 1'b0;
    e.found = found; e.fwd_chk = is_m; e.fwd = fwd; e.st = st;
    e.wb_addr = a; e.wb_data = fwd;
`ifdef SNOOP_WB_EN
    e.wb_exp = is_m; e.done_cyc = n + (is_m ? 4 + k : 2);
    e.wb_first = n + 3; e.wb_last = n + 3 + k;
`else
    e.wb_exp = 1'b0; e.done_cyc = n + (is_m ? 3 : 2);
    e.wb_first = -1; e.wb_last = -1;
`endif
    sb.push_back(e);
    for (int t = 0; t < 40 && !fin; t++) begin
      @(negedge clk);
      bus.cpu_search = 1'b0;
      bus.loc_we = 1'b0; bus.loc_addr = a;
      if (busy_chk && cyc == n + 1) begin
        bus.loc_we = 1'b1; bus.loc_addr = a ^ 13'h0008; bus.loc_state = MsiM;
      end
      if (busy_chk && cyc == n + 2) begin
        bus.loc_we = 1'b1; bus.loc_addr = a ^ 13'h0001; bus.loc_state = MsiM;
      end
      #1;
      if (busy_chk && cyc == n + 1) begin
        n_cmp++;
        if (bus.loc_busy !== 1'b1) begin
          n_fail++; $display("FAIL busy_same_idx: loc_busy=%b want 1", bus.loc_busy);
        end
      end
      if (busy_chk && cyc == n + 2) begin
        n_cmp++;
        if (bus.loc_busy !== 1'b0) begin
          n_fail++; $display("FAIL busy_other_idx: loc_busy=%b want 0", bus.loc_busy);
        end
      end
      if (bus.wb_req === 1'b1) begin
        if (wb_cnt == 0) wb_first = cyc;
        wb_last = cyc;
        n_cmp++;
        if (bus.wb_addr !== a || bus.wb_data !== fwd) begin
          n_fail++;
          $display("FAIL wb_payload: addr=%h data=%h want addr=%h data=%h",
                   bus.wb_addr, bus.wb_data, a, fwd);
        end
        bus.wb_rdy = (wb_cnt >= k);
        wb_cnt++;
      end else begin
        bus.wb_rdy = 1'b0;
      end
      if (bus.snoop_done === 1'b1) begin
        fin = 1'b1;
        g = sb.pop_front();
        n_cmp++;
        if (bus.cpu_search_found !== g.found) begin
          n_fail++; $display("FAIL found@%h: got %b want %b", a, bus.cpu_search_found, g.found);
        end
        n_cmp++;
        if (cyc != g.done_cyc) begin
          n_fail++; $display("FAIL done_cycle@%h: got N+%0d want N+%0d", a, cyc - n,
                             g.done_cyc - n);
        end
        if (g.fwd_chk) begin
          n_cmp++;
          if (bus.send_other_proc_data !== g.fwd) begin
            n_fail++; $display("FAIL fwd_data@%h: got %h want %h", a,
                               bus.send_other_proc_data, g.fwd);
          end
        end
        n_cmp++;
        if (bus.loc_state_out !== g.st) begin
          n_fail++; $display("FAIL state_at_done@%h: got %b want %b", a, bus.loc_state_out, g.st);
        end
        n_cmp++;
        if (g.wb_exp) begin
          if (wb_first != g.wb_first || wb_last != g.wb_last) begin
            n_fail++; $display("FAIL wb_window@%h: got N+%0d..N+%0d want N+%0d..N+%0d", a,
                               wb_first - n, wb_last - n, g.wb_first - n, g.wb_last - n);
          end
        end else if (wb_cnt != 0) begin
          n_fail++; $display("FAIL wb_absent@%h: wb_req cycles=%0d want 0", a, wb_cnt);
        end
      end
    end
    bus.loc_we = 1'b0; bus.wb_rdy = 1'b0;
    if (!fin) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout@%h: no snoop_done within 40 cycles", a);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [1:0] s;
    bus.cpu_search = 1'b0; bus.BOCI = '0; bus.invalidate_from_other_cpu = 1'b0;
    bus.wb_rdy = 1'b0; bus.loc_we = 1'b0; bus.loc_addr = '0; bus.loc_state = MsiI;
    for (int i = 0; i < int'(LINES); i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.snoop_done, bus.cpu_search_found, bus.wb_req, bus.dary_re, bus.loc_busy} !== 5'b0)
    begin
      n_fail++; $display("FAIL reset_ctrl: done/found/wb/re/busy=%b want 00000",
                         {bus.snoop_done, bus.cpu_search_found, bus.wb_req, bus.dary_re,
                          bus.loc_busy});
    end
    n_cmp++;
    if (bus.send_other_proc_data !== '0) begin
      n_fail++; $display("FAIL reset_fwd: got %h want 0", bus.send_other_proc_data);
    end
    peek(13'h0000, s);
    n_cmp++;
    if (s !== MsiI) begin
      n_fail++; $display("FAIL reset_state0: got %b want %b", s, MsiI);
    end
  endtask

  task automatic test_miss();
    run_snoop(13'h0005, 1'b0, 1'b0, 0, 1'b0, '0, MsiI, 1'b0);
    run_snoop(13'h0005, 1'b1, 1'b0, 0, 1'b0, '0, MsiI, 1'b0);
  endtask

  task automatic test_s_snoop();
    logic [1:0] s;
    loc_write(13'h0013, MsiS);
    peek(13'h0013, s);
    n_cmp++;
    if (s !== MsiS) begin
      n_fail++; $display("FAIL loc_fill_s: got %b want %b", s, MsiS);
    end
    run_snoop(13'h0013, 1'b1, 1'b0, 0, 1'b1, '0, MsiI, 1'b0);
    loc_write(13'h0021, MsiS);
    run_snoop(13'h0021, 1'b0, 1'b0, 0, 1'b1, '0, MsiS, 1'b0);
  endtask

  task automatic test_m_snoop();
    mem[2] = 16'hBEEF;
    loc_write(13'h0042, MsiM);
    run_snoop(13'h0042, 1'b0, 1'b1, 3, 1'b1, 16'hBEEF, MsiAfterRd, 1'b0);
    run_snoop(13'h0005, 1'b0, 1'b0, 0, 1'b0, '0, MsiI, 1'b0);
    n_cmp++;
    if (bus.send_other_proc_data !== 16'hBEEF) begin
      n_fail++; $display("FAIL fwd_hold: got %h want BEEF", bus.send_other_proc_data);
    end
    mem[2] = 16'h0F0F;
    loc_write(13'h0042, MsiM);
    run_snoop(13'h0042, 1'b1, 1'b1, 0, 1'b1, 16'h0F0F, MsiI, 1'b0);
  endtask

  task automatic test_tag_mismatch();
    logic [1:0] s;
    loc_write(13'h0042, MsiM);
    run_snoop(13'h004A, 1'b0, 1'b0, 0, 1'b0, '0, MsiI, 1'b0);
    @(negedge clk);
    peek(13'h0042, s);
    n_cmp++;
    if (s !== MsiM) begin
      n_fail++; $display("FAIL mismatch_keeps_m: got %b want %b", s, MsiM);
    end
  endtask

  task automatic test_busy();
    logic [1:0] s;
    mem[2] = 16'h1234;
    loc_write(13'h0042, MsiM);
    run_snoop(13'h0042, 1'b0, 1'b1, 1, 1'b1, 16'h1234, MsiAfterRd, 1'b1);
    @(negedge clk);
    peek(13'h0043, s);
    n_cmp++;
    if (s !== MsiM) begin
      n_fail++; $display("FAIL busy_other_write: got %b want %b", s, MsiM);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] s;
    mem[2] = 16'h5A5A;
    loc_write(13'h0042, MsiM);
    @(negedge clk);
    bus.cpu_search = 1'b1; bus.BOCI = 13'h0042; bus.invalidate_from_other_cpu = 1'b0;
    bus.wb_rdy = 1'b0;
    @(negedge clk);
    bus.cpu_search = 1'b0;
    @(negedge clk);
`ifdef SNOOP_WB_EN
    @(negedge clk);
    n_cmp++;
    if (bus.wb_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_wb_req_up: got %b want 1", bus.wb_req);
    end
`endif
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.wb_req !== 1'b0 || bus.snoop_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_async: wb_req=%b done=%b want 0 0",
                         bus.wb_req, bus.snoop_done);
    end
    peek(13'h0042, s);
    n_cmp++;
    if (s !== MsiI) begin
      n_fail++; $display("FAIL mid_reset_state: got %b want %b", s, MsiI);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_snoop(13'h0042, 1'b0, 1'b0, 0, 1'b0, '0, MsiI, 1'b0);
  endtask

  initial begin
    test_reset();
    test_miss();
    test_s_snoop();
    test_m_snoop();
    test_tag_mismatch();
    test_busy();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
